// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready producers.
// A grant is held until a last beat or MAX_BURST beats, so packets reach the FIFO contiguously.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_insert,
  output logic [DATA_WIDTH-1:0]         fifo_entry,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                state_r;
  logic [ID_W-1:0]       rr_ptr_r;
  logic [ID_W-1:0]       owner_r;
  logic [CNT_W-1:0]      beat_cnt_r;
  logic [DATA_WIDTH-1:0] entry_r;

  logic [DATA_WIDTH-1:0] data_arr_s [NUM_REQ];
  logic [ID_W-1:0]       pick_s;
  logic [ID_W-1:0]       idx_s;
  logic                  found_s;
  logic                  hit_s;
  logic                  xfer_s;
  logic                  release_s;
  int                    idx_v;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr_s[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotating-priority search: first valid requester at rr_ptr, rr_ptr+1, ... modulo NUM_REQ
  always_comb begin
    pick_s  = {ID_W{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = {ID_W{1'b0}};
    idx_v   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_v   = (int'(rr_ptr_r) + i) % NUM_REQ;
      idx_s   = ID_W'(idx_v);
      hit_s   = !found_s && req_valid[idx_s];
      pick_s  = hit_s ? idx_s : pick_s;
      found_s = found_s | hit_s;
    end
  end

  // A stalled owner or a full FIFO simply freezes the burst; both are absorbed by xfer_s
  assign xfer_s      = (state_r == ST_GRANT) && req_valid[owner_r] && !fifo_full;
  assign release_s   = xfer_s && (req_last[owner_r] || (beat_cnt_r == CNT_W'(MAX_BURST - 1)));
  assign fifo_insert = xfer_s;
  assign fifo_entry  = xfer_s ? data_arr_s[owner_r] : entry_r;
  assign busy        = (state_r == ST_GRANT);
  assign grant_id    = owner_r;

  // Ready goes only to the current owner, and only while the FIFO can accept
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if ((state_r == ST_GRANT) && !fifo_full) begin
      req_ready[owner_r] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Arbitration FSM, burst beat counter and last-written-data hold register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= {ID_W{1'b0}};
      owner_r    <= {ID_W{1'b0}};
      beat_cnt_r <= {CNT_W{1'b0}};
      entry_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            owner_r    <= pick_s;
            beat_cnt_r <= {CNT_W{1'b0}};
            state_r    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (xfer_s) begin
            entry_r    <= data_arr_s[owner_r];
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
          end
          if (release_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= (owner_r == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : owner_r + ID_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
